// File: rtl/mix_columns_engine.sv
// mix_columns_engine: iterative AES MixColumns / InvMixColumns stage.
// Mixes COLS_PER_CYCLE 32-bit columns of the 128-bit state per RUN cycle
// and holds the finished block on data_out until downstream accepts it.
// Optional feature macro: MIX_COLUMNS_BYPASS_EN adds a 'bypass' input that
// passes the block through unmixed (final AES round) with identical timing.
//
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both 1. Ready never depends on valid. A producer holds its data stable
// while valid=1 and ready=0. Here in_ready is 1 only in IDLE, and out_valid
// is 1 only in DONE, so an output handshake and an input accept can never
// share an edge.
module mix_columns_engine #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] data_in,
   input  logic         inverse,
`ifdef MIX_COLUMNS_BYPASS_EN
   input  logic         bypass,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] data_out,
   output logic         busy,
   output logic [1:0]   state_dbg
);

   localparam int         N_STEPS  = 4 / COLS_PER_CYCLE;
   localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $fatal(1, "mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4 (N_STEPS=%0d)", N_STEPS);
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic [127:0] work_q;
   logic [127:0] result_q;
   logic         mode_q;
   logic [1:0]   col_cnt;
   logic         accept;
   logic         last_step;
`ifdef MIX_COLUMNS_BYPASS_EN
   logic         bypass_q;
`endif

   // GF(2^8) multiply by 02 modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // One column through MixColumns (inv=0) or InvMixColumns (inv=1).
   // Byte 0 is the most significant byte of the column word.
   function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
      logic [7:0]  a  [4];
      logic [7:0]  x2 [4];
      logic [7:0]  x4 [4];
      logic [7:0]  x8 [4];
      logic [31:0] res;
      res = 32'h0;
      for (int r = 0; r < 4; r++) begin
         a[r]  = col[8*(3-r) +: 8];
         x2[r] = xt(a[r]);
         x4[r] = xt(x2[r]);
         x8[r] = xt(x4[r]);
      end
      for (int r = 0; r < 4; r++) begin
         if (!inv) begin
            // 02.a0 ^ 03.a1 ^ a2 ^ a3
            res[8*(3-r) +: 8] = x2[r] ^ (x2[(r+1)%4] ^ a[(r+1)%4])
                              ^ a[(r+2)%4] ^ a[(r+3)%4];
         end else begin
            // 0E.a0 ^ 0B.a1 ^ 0D.a2 ^ 09.a3
            res[8*(3-r) +: 8] = (x8[r] ^ x4[r] ^ x2[r])
                              ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                              ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                              ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
         end
      end
      return res;
   endfunction

   // Column slots handled this cycle and their mixed values.
   logic [1:0]  col_idx  [COLS_PER_CYCLE];
   logic [6:0]  col_base [COLS_PER_CYCLE];
   logic [31:0] col_mix  [COLS_PER_CYCLE];

   // Select the working columns and mix them (or pass them through).
   always_comb begin
      for (int j = 0; j < COLS_PER_CYCLE; j++) begin
         col_idx[j]  = col_cnt + 2'(j);
         // column c occupies bits [127-32c -: 32] = [32*(3-c) +: 32]
         col_base[j] = {~col_idx[j], 5'd0};
         col_mix[j]  = mix_col(work_q[col_base[j] +: 32], mode_q);
`ifdef MIX_COLUMNS_BYPASS_EN
         if (bypass_q) begin
            col_mix[j] = work_q[col_base[j] +: 32];
         end
`endif
      end
   end

   assign last_step = (col_cnt == LAST_CNT);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = rst_n;
            accept   = in_valid && rst_n;
            if (accept) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            busy = 1'b1;
            if (last_step) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Datapath: latch the block at accept, fill result columns during RUN.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         work_q   <= 128'h0;
         result_q <= 128'h0;
         mode_q   <= 1'b0;
         col_cnt  <= 2'd0;
`ifdef MIX_COLUMNS_BYPASS_EN
         bypass_q <= 1'b0;
`endif
      end else if (accept) begin
         work_q  <= data_in;
         mode_q  <= inverse;
         col_cnt <= 2'd0;
`ifdef MIX_COLUMNS_BYPASS_EN
         bypass_q <= bypass;
`endif
      end else if (state_q == ST_RUN) begin
         for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            result_q[col_base[j] +: 32] <= col_mix[j];
         end
         col_cnt <= col_cnt + COL_STEP;
      end
   end

   assign data_out  = result_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// tb_mix_columns_engine: drives three engine instances (1, 2 and 4 columns
// per cycle) and checks them against a GF(2^8) reference model.
module tb_mix_columns_engine;

   localparam int NI = 3;

   localparam logic [127:0] FWD_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
   localparam logic [127:0] FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
   localparam logic [127:0] LAT_IN  = 128'hc6c6c6c6_d4d4d4d5_c6c6c6c6_d4d4d4d5;
   localparam logic [127:0] LAT_OUT = 128'hc6c6c6c6_d5d5d7d6_c6c6c6c6_d5d5d7d6;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid  [NI];
   logic         in_ready  [NI];
   logic [127:0] data_in   [NI];
   logic         inverse   [NI];
   logic         bypass    [NI];
   logic         out_valid [NI];
   logic         out_ready [NI];
   logic [127:0] data_out  [NI];
   logic         busy      [NI];
   logic [1:0]   state_dbg [NI];

   int total = 0;
   int bad   = 0;
   logic [127:0] exp_q [NI][$];

   // clock
   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      mix_columns_engine #(.COLS_PER_CYCLE(1 << g)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .data_in   (data_in[g]),
         .inverse   (inverse[g]),
`ifdef MIX_COLUMNS_BYPASS_EN
         .bypass    (bypass[g]),
`endif
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .data_out  (data_out[g]),
         .busy      (busy[g]),
         .state_dbg (state_dbg[g])
      );
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ (16'(a) << i);
      end
      for (int i = 15; i >= 8; i--) begin
         if (p[i]) p = p ^ (16'h11b << (i - 8));
      end
      return p[7:0];
   endfunction

   function automatic logic [127:0] model(input logic [127:0] d, input logic inv, input logic byp);
      logic [7:0]   m [4];
      logic [7:0]   acc;
      logic [127:0] res;
      if (inv) begin
         m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
      end else begin
         m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
      end
      res = 128'h0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            acc = 8'h0;
            for (int k = 0; k < 4; k++) begin
               acc = acc ^ gmul(m[k], d[127 - 32*c - 8*((r + k) % 4) -: 8]);
            end
            res[127 - 32*c - 8*r -: 8] = byp ? d[127 - 32*c - 8*r -: 8] : acc;
         end
      end
      return res;
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Every cycle an output is valid, it must match the oldest expected block.
   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (rst_n && out_valid[k]) begin
            if (exp_q[k].size() == 0) begin
               check($sformatf("unexpected_out_valid_%0d", k), 128'(out_valid[k]), 128'h0);
            end else begin
               check($sformatf("data_out_%0d", k), data_out[k], exp_q[k][0]);
            end
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic send(input int k, input logic [127:0] d, input logic inv, input logic byp,
                       input logic [127:0] expv, input bit scramble);
      int w;
      int lat;
      w = 0;
      @(negedge clk);
      while (!in_ready[k] && w < 20) begin
         @(negedge clk);
         w++;
      end
      check($sformatf("in_ready_before_send_%0d", k), 128'(in_ready[k]), 128'h1);
      in_valid[k] = 1'b1;
      data_in[k]  = d;
      inverse[k]  = inv;
      bypass[k]   = byp;
      exp_q[k].push_back(expv);
      @(posedge clk);
      @(negedge clk);
      if (!scramble) in_valid[k] = 1'b0;
      lat = 0;
      while (!out_valid[k] && lat < 20) begin
         if (scramble) begin
            data_in[k] = {$urandom, $urandom, $urandom, $urandom};
            inverse[k] = ~inverse[k];
            bypass[k]  = ~bypass[k];
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      in_valid[k] = 1'b0;
      check($sformatf("latency_%0d", k), 128'(lat), 128'(4 >> k));
   endtask

   task automatic drain(input int k, input int hold);
      logic [127:0] snap;
      logic [1:0]   sd;
      snap = data_out[k];
      sd   = state_dbg[k];
      out_ready[k] = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_data", data_out[k], snap);
         check("hold_in_ready", 128'(in_ready[k]), 128'h0);
         check("hold_out_valid", 128'(out_valid[k]), 128'h1);
         check("hold_state", 128'(state_dbg[k]), 128'(sd));
      end
      out_ready[k] = 1'b1;
      @(posedge clk);
      if (exp_q[k].size() > 0) void'(exp_q[k].pop_front());
      @(negedge clk);
      out_ready[k] = 1'b0;
      check("post_out_valid", 128'(out_valid[k]), 128'h0);
      check("post_in_ready", 128'(in_ready[k]), 128'h1);
      check("post_busy", 128'(busy[k]), 128'h0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [127:0] d;
      logic         inv;
      logic         byp;
      int           k;

      for (int i = 0; i < NI; i++) begin
         in_valid[i]  = 1'b0;
         data_in[i]   = 128'h0;
         inverse[i]   = 1'b0;
         bypass[i]    = 1'b0;
         out_ready[i] = 1'b0;
      end

      // reset
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) check("reset_in_ready_low", 128'(in_ready[i]), 128'h0);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         check("reset_in_ready", 128'(in_ready[i]), 128'h1);
         check("reset_out_valid", 128'(out_valid[i]), 128'h0);
         check("reset_busy", 128'(busy[i]), 128'h0);
         check("reset_data_out", data_out[i], 128'h0);
      end

      // forward known vector
      send(0, FWD_IN, 1'b0, 1'b0, FWD_OUT, 1'b0);
      drain(0, 0);

      // inverse round trip on every width; backpressure on the 1-column unit
      for (int i = 0; i < NI; i++) begin
         send(i, FWD_OUT, 1'b1, 1'b0, FWD_IN, 1'b0);
         drain(i, (i == 0) ? 10 : 1);
      end

      // mode/data latched at accept; inputs churn during RUN
      send(0, LAT_IN, 1'b0, 1'b0, LAT_OUT, 1'b1);
      drain(0, 2);

      // reset in the middle of a block
      @(negedge clk);
      in_valid[0] = 1'b1;
      data_in[0]  = FWD_IN;
      inverse[0]  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      exp_q[0].delete();
      @(posedge clk);
      @(negedge clk);
      check("midrun_out_valid", 128'(out_valid[0]), 128'h0);
      check("midrun_busy", 128'(busy[0]), 128'h0);
      check("midrun_in_ready", 128'(in_ready[0]), 128'h0);
      for (int i = 0; i < NI; i++) check("midrun_data_out", data_out[i], 128'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("after_reset_in_ready", 128'(in_ready[0]), 128'h1);
      send(0, FWD_IN, 1'b0, 1'b0, FWD_OUT, 1'b0);
      drain(0, 1);

`ifdef MIX_COLUMNS_BYPASS_EN
      // bypass passes the state through with normal timing
      for (int i = 0; i < NI; i++) begin
         send(i, FWD_IN, 1'b0, 1'b1, FWD_IN, 1'b0);
         drain(i, 0);
      end
`endif

      // randomized blocks against the model
      for (int n = 0; n < 60; n++) begin
         k   = $urandom_range(0, NI - 1);
         d   = {$urandom, $urandom, $urandom, $urandom};
         inv = 1'($urandom_range(0, 1));
`ifdef MIX_COLUMNS_BYPASS_EN
         byp = ($urandom_range(0, 3) == 0);
`else
         byp = 1'b0;
`endif
         send(k, d, inv, byp, model(d, inv, byp), 1'b0);
         drain(k, $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mix_columns_engine.md
Name: mix_columns_engine

Overview:
- Iterative AES MixColumns / InvMixColumns unit with a per-block mode select and valid/ready handshakes on input and output.
- Processes COLS_PER_CYCLE 32-bit columns of the 128-bit state per clock and holds the result until it is accepted downstream.
- Serves as the shared column-mixing stage of the round datapath for both the encrypt and decrypt flows.

Parameters:
- COLS_PER_CYCLE, 1, columns mixed per RUN cycle. Legal values: 1, 2, 4. Any other value is a fatal elaboration error.
- N_STEPS, 4/COLS_PER_CYCLE, derived local constant: number of RUN cycles per block.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  data_in/inverse are valid.
- in_ready  output  1  engine can accept a block.
- data_in  input  128  state. Column c = bits [127-32c -: 32]. Byte r of a column = bits [127-32c-8r -: 8].
- inverse  input  1  0 = MixColumns, 1 = InvMixColumns. Sampled with data_in.
- out_valid  output  1  data_out holds a finished block.
- out_ready  input  1  downstream accepts data_out.
- data_out  output  128  result, same byte layout as data_in.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: synchronous, active-low. Sampled on the rising edge of clk.
  - Forces IDLE and clears col_cnt, the result register and the mode register.
  - Output values during reset: in_ready=0 while rst_n=0; then in_ready=1, out_valid=0, busy=0, data_out=0.
  - Reset asserted in RUN or DONE aborts the block with no output.
- State machine:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch data_in into the work register and inverse into the mode register, clear col_cnt, go to RUN.
  - RUN: in_ready=0. Each cycle mixes columns col_cnt..col_cnt+COLS_PER_CYCLE-1 of the work register and writes them into the same column slots of the result register; col_cnt advances by COLS_PER_CYCLE. After the N_STEPS-th RUN cycle, go to DONE and set out_valid=1.
  - DONE: out_valid=1 and data_out stable. On out_ready=1, go to IDLE. in_ready stays 0 in DONE, so no accept occurs on the same edge as the output handshake. in_ready rises in the following cycle.
- Timing:
  - Latency from accept edge to out_valid=1 is N_STEPS cycles (4 / 2 / 1).
  - Minimum block period is N_STEPS+2 cycles when out_ready is held at 1.
- Column arithmetic, for a column a0..a3 (GF(2^8), polynomial 0x11B):
  - Forward: b_r = 02·a_r ^ 03·a_(r+1) ^ a_(r+2) ^ a_(r+3), indices mod 4.
  - Inverse: b_r = 0E·a_r ^ 0B·a_(r+1) ^ 0D·a_(r+2) ^ 09·a_(r+3).
  - Implementation: xtime-based constant multipliers only. No general multiplier loops.
- Input and mode handling:
  - Mode is the value latched at accept. Changes to inverse or data_in after accept have no effect on the block in flight.
  - in_valid is ignored outside IDLE. The upstream holds its data until in_ready=1.
- col_cnt is 2 bits. It wraps to 0 after the final step and is reset to 0 on accept.
- out_ready while not in DONE is ignored.

Optional Feature:
- Macro: MIX_COLUMNS_BYPASS_EN.
- Defined:
  - Adds input port bypass (1 bit), latched at accept alongside inverse.
  - When the latched bypass=1, the result register receives the input columns unmodified (used for the final AES round).
  - Latency and handshakes are identical to a normal block.
- Undefined: the port is absent, and every block is mixed.

Test Plan:
- Forward, COLS_PER_CYCLE=1: data_in=db135345_f20a225c_01010101_2d26314c, inverse=0 -> out_valid exactly 4 cycles after the accept edge, data_out=8e4da1bc_9fdc589d_01010101_4d7ebdf8.
- Inverse round trip, COLS_PER_CYCLE=1/2/4: data_in=8e4da1bc_9fdc589d_01010101_4d7ebdf8, inverse=1 -> data_out=db135345_f20a225c_01010101_2d26314c, with latency 4/2/1 respectively.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> data_out stable and in_ready=0 throughout. out_ready=1 -> IDLE next cycle, in_ready=1 on the following cycle.
- Mode latch: accept c6c6c6c6_d4d4d4d5_c6c6c6c6_d4d4d4d5 with inverse=0, then toggle inverse and data_in during RUN -> data_out=c6c6c6c6_d5d5d7d6_c6c6c6c6_d5d5d7d6.
- Reset mid-RUN: rst_n=0 on cycle 2 of a COLS_PER_CYCLE=1 block -> next edge out_valid=0, data_out=0, busy=0. After release, in_ready=1, and a fresh block completes correctly.
- MIX_COLUMNS_BYPASS_EN defined, bypass=1: data_in=db135345_f20a225c_01010101_2d26314c -> data_out identical to data_in after N_STEPS cycles.
